avr_tx_arbiter: RTL
===================

# avr_tx_arbiter

Round-robin, frame-locking arbiter that shares the single serial byte channel toward the AVR (avr_rx pin) between NUM_REQ on-chip byte producers. Sits between the requesters and the existing serial transmitter: it issues one-cycle new-data strobes, honours transmitter busy and AVR flow control (avr_rx_busy), and holds the channel for a requester until that requester's frame completes or stalls too long.

## Interface
- NUM_REQ, 4: number of requesters, 2..8
- STALL_MAX, 1024: max consecutive cycles an owner may leave in_valid low mid-frame before forced release
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  NUM_REQ  per-requester byte valid
- in_data  in  8*NUM_REQ  per-requester byte; requester i on bits [8i+7:8i]
- in_last  in  NUM_REQ  per-requester end-of-frame flag, qualified by in_valid
- in_ready  out  NUM_REQ  per-requester accept; at most one bit high; a byte transfers when in_valid[i] && in_ready[i]
- tx_data  out  8  byte to serial transmitter, held stable from strobe until next strobe
- tx_new_data  out  1  one-cycle strobe to transmitter
- tx_busy  in  1  transmitter busy, rises the cycle after tx_new_data
- tx_block  in  1  AVR flow control (avr_rx_busy); no strobe while high
- owner  out  clog2(NUM_REQ)  current/last granted requester index
- active  out  1  channel locked to owner
- stall_drop  out  1  one-cycle pulse when an owner is force-released by STALL_MAX

## Operation
- States: IDLE, SEND, SETTLE, WAIT.
- IDLE: if any in_valid, grant the first requester with in_valid set, searching upward from rr_ptr with wrap; latch owner, set active, go SEND. No requests: stay.
- SEND: when in_valid[owner] && !tx_busy && !tx_block: in_ready[owner]=1 combinationally this cycle, tx_data<=in_data[owner], tx_new_data=1 next cycle (registered), latch in_last[owner] into last_r, go SETTLE. Otherwise in_ready all zero, stay.
- SETTLE: exactly one cycle (covers transmitter busy rise); go WAIT.
- WAIT: when !tx_busy: last_r=1 -> rr_ptr<=owner+1 (wrap at NUM_REQ), clear active, IDLE; else SEND.
- Stall counter: counts SEND cycles with in_valid[owner]=0; cleared on every accepted byte and on grant. Reaching STALL_MAX-1 -> pulse stall_drop, rr_ptr<=owner+1, IDLE. tx_block or tx_busy stalls do not count.
- Frame lock: other requesters never receive in_ready while active, regardless of priority.
- Single-byte frame (in_last on first byte) legal; releases after that byte.
- Requester deasserting in_valid in IDLE before grant: no grant, no side effects.

## Timing
- Reset (clk edge with rst=1): state IDLE, in_ready=0, tx_new_data=0, tx_data=8'h00, owner=0, active=0, stall_drop=0, rr_ptr=0, stall counter=0, last_r=0. Reset mid-frame abandons the frame; no strobe is emitted in the reset cycle or after.
- Grant latency: in_valid rise in IDLE -> active high next cycle -> earliest in_ready the cycle after.
- Acceptance -> tx_new_data: 1 cycle. Minimum per-byte spacing in SEND/SETTLE/WAIT loop: 3 cycles plus transmitter busy time.
- tx_block sampled only in SEND; rising tx_block after the strobe does not cancel the byte.
- Simultaneous in_last and stall threshold cannot coincide (accept clears counter); accept wins.

## Structure
- Shared package: state encoding enum, OWNER_W = clog2(NUM_REQ) helper.
- One sub-module natural: rr_pick (combinational round-robin priority encoder: valid vector + pointer -> index + found). Everything else in avr_tx_arbiter.

## Test plan
- Single requester 1, frame 8'h41,8'h42(last), tx_busy modelled 10 cycles -> two strobes with tx_data 41 then 42, active drops after second byte, rr_ptr=2.
- Requesters 0 and 2 valid together from reset -> 0 granted first, full frame sent; then 2 granted; 0's new request waits until 2's last.
- Fairness: all four continuously sending 1-byte frames -> owner sequence 0,1,2,3,0,... with no repeats.
- tx_block held high 50 cycles during owner's frame -> no strobe, no in_ready, no stall_drop; first strobe 1 cycle after block falls and byte accepted.
- Owner drops in_valid mid-frame, STALL_MAX=16 -> stall_drop pulses once after 16 SEND cycles, next requester granted.
- rst asserted in WAIT mid-frame -> all outputs at reset values next cycle, no further tx_new_data until new grant.

Source files
------------

// File: rtl/avr_tx_arbiter_pkg.sv
// rtl/avr_tx_arbiter_pkg.sv - shared state encoding and width helper for the AVR tx arbiter
package avr_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_SETTLE,
    ST_WAIT
  } arb_state_t;

  function automatic int owner_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/avr_tx_arbiter_rr_pick.sv
// rtl/avr_tx_arbiter_rr_pick.sv - round-robin priority encoder: first valid at or above ptr, with wrap
module avr_tx_arbiter_rr_pick
  import avr_tx_arbiter_pkg::*;
#(
  parameter int N = 4,
  parameter int W = owner_w(N)
) (
  input  logic [N-1:0] valid,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         found
);

  logic [W-1:0] cand;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = ptr;
    for (int k = 0; k < N; k++) begin
      if (!found && valid[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
      cand = (cand == W'(N - 1)) ? '0 : cand + W'(1);
    end
  end

endmodule

// File: rtl/avr_tx_arbiter.sv
// rtl/avr_tx_arbiter.sv - frame-locking round-robin arbiter for the serial byte channel toward the AVR
module avr_tx_arbiter
  import avr_tx_arbiter_pkg::*;
#(
  parameter int  NUM_REQ   = 4,
  parameter int  STALL_MAX = 1024,
  localparam int OWNER_W   = owner_w(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     in_valid,
  input  logic [8*NUM_REQ-1:0]   in_data,
  input  logic [NUM_REQ-1:0]     in_last,
  output logic [NUM_REQ-1:0]     in_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_new_data,
  input  logic                   tx_busy,
  input  logic                   tx_block,
  output logic [OWNER_W-1:0]     owner,
  output logic                   active,
  output logic                   stall_drop
);

  localparam int CNT_W = $clog2(STALL_MAX);
  localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(STALL_MAX - 1);

  arb_state_t         state_q, state_d;
  logic [OWNER_W-1:0] owner_q, owner_d;
  logic [OWNER_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               last_q, last_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_new_data_q, tx_new_data_d;
  logic               stall_drop_q, stall_drop_d;

  logic [OWNER_W-1:0] pick_idx;
  logic               pick_found;
  logic [OWNER_W-1:0] next_ptr;

  avr_tx_arbiter_rr_pick #(
    .N (NUM_REQ),
    .W (OWNER_W)
  ) u_rr_pick (
    .valid (in_valid),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    next_ptr      = (owner_q == OWNER_W'(NUM_REQ - 1)) ? '0 : owner_q + OWNER_W'(1);
    state_d       = state_q;
    owner_d       = owner_q;
    rr_ptr_d      = rr_ptr_q;
    stall_cnt_d   = stall_cnt_q;
    last_d        = last_q;
    tx_data_d     = tx_data_q;
    tx_new_data_d = 1'b0;
    stall_drop_d  = 1'b0;
    in_ready      = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          owner_d     = pick_idx;
          stall_cnt_d = '0;
          state_d     = ST_SEND;
        end
      end
      ST_SEND: begin
        if (in_valid[owner_q]) begin
          // Flow-control waits hold the counter: only an idle owner is a stall.
          if (!tx_busy && !tx_block) begin
            in_ready[owner_q] = 1'b1;
            tx_data_d         = in_data[{owner_q, 3'b000} +: 8];
            tx_new_data_d     = 1'b1;
            last_d            = in_last[owner_q];
            stall_cnt_d       = '0;
            state_d           = ST_SETTLE;
          end
        end else if (stall_cnt_q == STALL_LAST) begin
          stall_drop_d = 1'b1;
          rr_ptr_d     = next_ptr;
          stall_cnt_d  = '0;
          state_d      = ST_IDLE;
        end else begin
          stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
      end
      // One dead cycle so WAIT never sees tx_busy before the transmitter raises it.
      ST_SETTLE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (!tx_busy) begin
          if (last_q) begin
            rr_ptr_d = next_ptr;
            state_d  = ST_IDLE;
          end else begin
            state_d = ST_SEND;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      owner_q       <= '0;
      rr_ptr_q      <= '0;
      stall_cnt_q   <= '0;
      last_q        <= 1'b0;
      tx_data_q     <= 8'h00;
      tx_new_data_q <= 1'b0;
      stall_drop_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      rr_ptr_q      <= rr_ptr_d;
      stall_cnt_q   <= stall_cnt_d;
      last_q        <= last_d;
      tx_data_q     <= tx_data_d;
      tx_new_data_q <= tx_new_data_d;
      stall_drop_q  <= stall_drop_d;
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_new_data = tx_new_data_q;
  assign owner       = owner_q;
  assign active      = (state_q != ST_IDLE);
  assign stall_drop  = stall_drop_q;

endmodule
